// File: rtl/logic_unit_arbiter_if.sv
// Request/response bus between the clients and logic_unit_arbiter.
//  req_valid/req_ready : per-requester handshake (NREQ bits)
//  req_op/req_a/req_b  : packed per-requester opcode (3 bits) and operands (WIDTH bits)
//  rsp_valid/rsp_ready : response handshake
//  rsp_id/rsp_data/rsp_err : owning requester, result, illegal-opcode flag
// master = client side, slave = arbiter side.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Shares one WIDTH-bit bitwise logic unit between NREQ requesters.
// Round-robin grant, one transaction in flight: IDLE (grant/capture) ->
// EXEC (compute, register result) -> RESP (hold until rsp_ready).
// Ports:
//  clk      rising-edge clock
//  rst      asynchronous active-high reset
//  bus      logic_unit_arbiter_if.slave request/response bus
//  busy     high whenever the FSM is not IDLE
//  op_count completed responses, saturating at 16'hFFFF
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [15:0]          op_count
);
  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    scan_idx;
  logic             found;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    id_q;
  logic [WIDTH-1:0] result;
  logic             res_err;

  // Scan starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = IW'((32'(last_grant) + i) % NREQ);
      if (!found && bus.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = (state == IDLE) && found && (winner == IW'(i));
    end
  end

  always_comb begin
    result  = '0;
    res_err = 1'b0;
    case (op_q)
      3'd0:    result = a_q & b_q;
      3'd1:    result = a_q | b_q;
      3'd2:    result = ~a_q;
      3'd3:    result = ~(a_q & b_q);
      3'd4:    result = ~(a_q | b_q);
      3'd5:    result = a_q ^ b_q;
      3'd6:    result = ~(a_q ^ b_q);
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IW'(NREQ - 1);
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      busy         <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_q       <= bus.req_op[3*winner +: 3];
            a_q        <= bus.req_a[WIDTH*winner +: WIDTH];
            b_q        <= bus.req_b[WIDTH*winner +: WIDTH];
            id_q       <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_data  <= result;
          bus.rsp_err   <= res_err;
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (op_count != '1) op_count <= op_count + 16'd1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] op_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic_unit_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

  logic_unit_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 12 && !bus.rsp_valid; n++) tick();
    check("rsp_wait", 32'(bus.rsp_valid), 32'd1);
  endtask

  // Single-requester transaction; called just after a clock edge with FSM in IDLE.
  task automatic do_op(input int unsigned id, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input logic err);
    bus.req_valid          = '0;
    bus.req_valid[id]      = 1'b1;
    bus.req_op[3*id +: 3]  = op;
    bus.req_a[8*id +: 8]   = a;
    bus.req_b[8*id +: 8]   = b;
    #1;
    check("grant", 32'(bus.req_ready), 32'(4'b0001 << id));
    tick();
    bus.req_valid = '0;
    check("busy_exec", 32'(busy), 32'd1);
    check("ready_exec", 32'(bus.req_ready), 32'd0);
    tick();
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_data", 32'(bus.rsp_data), 32'(exp));
    check("rsp_id", 32'(bus.rsp_id), id);
    check("rsp_err", 32'(bus.rsp_err), 32'(err));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_done", 32'(bus.rsp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    #12;
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_data", 32'(bus.rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    tick();
    rst = 1'b0;

    // Basic AND from requester 0.
    do_op(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
    check("count_1", 32'(op_count), 32'd1);

    // Opcode sweep from requester 1.
    for (int k = 0; k < 8; k++)
      do_op(1, 3'(k), 8'hA5, 8'h0F, sweep_exp[k], k == 7);
    check("count_9", 32'(op_count), 32'd9);

    // Put last_grant at 3 so the rotation starts at 0.
    do_op(3, 3'd1, 8'h00, 8'h00, 8'h00, 1'b0);

    // All four requesting continuously; per-requester XOR data to tie data to id.
    bus.req_op = {3'd5, 3'd5, 3'd5, 3'd5};
    bus.req_a  = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.req_b  = {8'h04, 8'h03, 8'h02, 8'h01};
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_rsp();
      check("rr_id", 32'(bus.rsp_id), 32'(k % 4));
      check("rr_data", 32'(bus.rsp_data), 32'((k % 4 + 1) * 8'h11));
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    check("count_18", 32'(op_count), 32'd18);
    tick();

    // Grant to 2, then 1 and 3 compete: 3 wins before 1.
    do_op(2, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b1;
    #1;
    check("skip_ready", 32'(bus.req_ready), 32'b1000);
    wait_rsp();
    check("skip_id3", 32'(bus.rsp_id), 32'd3);
    tick();
    check("skip_ready1", 32'(bus.req_ready), 32'b0010);
    wait_rsp();
    check("skip_id1", 32'(bus.rsp_id), 32'd1);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // Backpressure: hold RESP 10 cycles with everyone else requesting.
    bus.req_op[2:0] = 3'd5;
    bus.req_a[7:0]  = 8'h3C;
    bus.req_b[7:0]  = 8'hFF;
    bus.req_valid   = 4'b0001;
    tick();
    bus.req_valid = 4'b1111;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_data", 32'(bus.rsp_data), 32'h00C3);
      check("bp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    check("bp_release", 32'(bus.rsp_valid), 32'd0);
    check("count_22", 32'(op_count), 32'd22);

    // Reset while in EXEC drops the transaction.
    bus.req_valid[3] = 1'b1;
    tick();
    bus.req_valid = '0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(op_count), 32'd0);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("dropped", 32'(bus.rsp_valid), 32'd0);
    do_op(3, 3'd4, 8'h0F, 8'h30, 8'hC0, 1'b0);
    check("count_post", 32'(op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
